// File: rtl/cla_pkg.sv
// Shared constants for the carry-lookahead adder slices.
// CLA_WIDTH is the width of one lookahead block; CLA_BLOCKS_32 is the number
// of blocks that make up the ALU's 32-bit adder.
package cla_pkg;

    localparam int CLA_WIDTH     = 8;
    localparam int CLA_BLOCKS_32 = 4;

    typedef logic [CLA_WIDTH-1:0] cla_word_t;

endpackage : cla_pkg

// File: rtl/cla_pg_cell.sv
// One-bit propagate/generate cell for the lookahead adder.
// Produces generate (a & b), OR-form propagate (a | b) and the half-sum
// (a ^ b). The half-sum is XORed with the bit's carry in the top block.
module cla_pg_cell (
    input  logic i_a,
    input  logic i_b,
    output logic o_g,
    output logic o_p,
    output logic o_hs
);

    assign o_g  = i_a & i_b;
    assign o_p  = i_a | i_b;
    assign o_hs = i_a ^ i_b;

endmodule : cla_pg_cell

// File: rtl/cla_8_bit_block.sv
// 8-bit carry-lookahead adder slice for the ALU's 32-bit adder.
// Every carry is a fully expanded sum of products of the bit generate and
// propagate terms, so no carry depends on another carry. Block P/G feed a
// second-level lookahead unit.
// Build option: define CLA_REG_OUT_EN to make sum_q/cout_q flip-flops;
// otherwise they are wired straight to sum/cout and clock/reset are unused.
module cla_8_bit_block
    import cla_pkg::*;
(
    output logic [CLA_WIDTH-1:0] sum,
    output logic                 cout,
    input  logic [CLA_WIDTH-1:0] a,
    input  logic [CLA_WIDTH-1:0] b,
    input  logic                 cin,
    input  logic                 clock,
    input  logic                 reset,
    output logic                 P,
    output logic                 G,
    output logic [CLA_WIDTH-1:0] sum_q,
    output logic                 cout_q
);

    cla_word_t w_g;
    cla_word_t w_p;
    cla_word_t w_hs;
    cla_word_t w_carry;   // w_carry[i] is the carry into bit i
    logic      w_blk_g;
    logic      w_blk_p;

    // Per-bit generate, propagate and half-sum.
    for (genvar gi = 0; gi < CLA_WIDTH; gi++) begin : g_pg
        cla_pg_cell u_pg_cell (
            .i_a  (a[gi]),
            .i_b  (b[gi]),
            .o_g  (w_g[gi]),
            .o_p  (w_p[gi]),
            .o_hs (w_hs[gi])
        );
    end

    // Expanded lookahead carries c1..c7:
    // c(i+1) = g_i | p_i g_(i-1) | ... | p_i..p_1 g_0 | p_i..p_0 cin.
    // The running product only accumulates p terms; no carry feeds another.
    always_comb begin
        // NOTE: every variable gets a value before any conditional or loop
        // path so no latch is inferred for a partially assigned bit.
        logic v_terms;
        logic v_prod;
        w_carry    = '0;
        v_terms    = 1'b0;
        v_prod     = 1'b0;
        w_carry[0] = cin;
        for (int i = 0; i < CLA_WIDTH - 1; i++) begin
            v_terms = w_g[i];
            v_prod  = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                v_terms = v_terms | (v_prod & w_g[j]);
                v_prod  = v_prod & w_p[j];
            end
            v_terms      = v_terms | (v_prod & cin);
            w_carry[i+1] = v_terms;
        end
    end

    // Block generate g7 | p7 g6 | ... | p7..p1 g0 and block propagate; both
    // are independent of cin.
    always_comb begin
        logic v_prod;
        w_blk_g = w_g[CLA_WIDTH-1];
        v_prod  = w_p[CLA_WIDTH-1];
        for (int j = CLA_WIDTH - 2; j >= 0; j--) begin
            w_blk_g = w_blk_g | (v_prod & w_g[j]);
            v_prod  = v_prod & w_p[j];
        end
        w_blk_p = &w_p;
    end

    assign sum  = w_hs ^ w_carry;
    assign P    = w_blk_p;
    assign G    = w_blk_g;
    assign cout = w_blk_g | (w_blk_p & cin);

`ifdef CLA_REG_OUT_EN
    cla_word_t r_sum_q;
    logic      r_cout_q;

    // Pipeline copy of the result; reset clears it without waiting for clock.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples its pre-edge input regardless of statement order.
        if (reset) begin
            r_sum_q  <= '0;
            r_cout_q <= 1'b0;
        end else begin
            r_sum_q  <= sum;
            r_cout_q <= cout;
        end
    end

    assign sum_q  = r_sum_q;
    assign cout_q = r_cout_q;
`else
    logic w_unused_clk_rst;

    // Unregistered build: the pipeline outputs are plain copies of the result.
    assign sum_q            = sum;
    assign cout_q           = cout;
    assign w_unused_clk_rst = clock | reset;
`endif

endmodule : cla_8_bit_block

// File: tb/tb_cla_8_bit_block.sv
// Self-checking bench for cla_8_bit_block: directed corner cases, an
// exhaustive combinational sweep, and randomized clocked traffic with reset
// pulses. Reference values come from plain integer arithmetic.
// Registered-output expectations follow the CLA_REG_OUT_EN build option.
`timescale 1ns/1ps
module tb_cla_8_bit_block;

    logic [7:0] sum;
    logic       cout;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       clock;
    logic       reset;
    logic       P;
    logic       G;
    logic [7:0] sum_q;
    logic       cout_q;

    int n_cmp = 0;
    int n_err = 0;
    logic clk_en = 1'b0;

    cla_8_bit_block dut (
        .sum    (sum),
        .cout   (cout),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .clock  (clock),
        .reset  (reset),
        .P      (P),
        .G      (G),
        .sum_q  (sum_q),
        .cout_q (cout_q)
    );

    // Gated clock: stopped during the exhaustive combinational sweep.
    initial clock = 1'b0;
    always #5 if (clk_en) clock = ~clock;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (a=%h b=%h cin=%b)", tag, got, exp, a, b, cin);
        end
    endtask

    // Reference: {cout,sum} is the 9-bit arithmetic sum.
    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return 9'(s);
    endfunction

    // Block generate: carry out with cin forced to 0.
    function automatic logic ref_g(input logic [7:0] x, input logic [7:0] y);
        return (int'(x) + int'(y)) > 255;
    endfunction

    // Block propagate: every bit has at least one operand bit set.
    function automatic logic ref_p(input logic [7:0] x, input logic [7:0] y);
        return (x | y) == 8'hFF;
    endfunction

    task automatic check_comb(input string tag);
        check({tag, ".sum"}, {cout, sum}, ref_add(a, b, cin));
        check({tag, ".P"},   9'(P),       9'(ref_p(a, b)));
        check({tag, ".G"},   9'(G),       9'(ref_g(a, b)));
    endtask

    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic c);
        a   = x;
        b   = y;
        cin = c;
    endtask

    logic [8:0] exp_q;

    initial begin
        reset = 1'b1;
        drive(8'h00, 8'h00, 1'b0);
        #1;
        check("reset.sum_q", {cout_q, sum_q}, 9'h000);
        check_comb("reset.comb");

        // Directed corners.
        drive(8'h00, 8'h00, 1'b1); #20;
        check("zero_cin.sum", {cout, sum}, 9'h001);
        check("zero_cin.P", 9'(P), 9'h0);
        check("zero_cin.G", 9'(G), 9'h0);
        drive(8'hFF, 8'h00, 1'b1); #20;
        check("prop_chain.sum", {cout, sum}, 9'h100);
        check("prop_chain.P", 9'(P), 9'h1);
        check("prop_chain.G", 9'(G), 9'h0);
        drive(8'hFF, 8'hFF, 1'b1); #20;
        check("ff_ff_1.sum", {cout, sum}, 9'h1FF);
        check("ff_ff_1.G", 9'(G), 9'h1);
        drive(8'hFF, 8'hFF, 1'b0); #20;
        check("ff_ff_0.sum", {cout, sum}, 9'h1FE);
        // Reset held: combinational outputs still track inputs.
        check("reset_held.sum_q", {cout_q, sum_q},
`ifdef CLA_REG_OUT_EN
              9'h000);
`else
              9'h1FE);
`endif

        reset = 1'b0;

        // Exhaustive sweep, cin=1 first then cin=0.
        for (int c = 1; c >= 0; c--) begin
            for (int x = 0; x < 65536; x++) begin
                drive(x[7:0], x[15:8], c[0]);
                #20;
                check_comb("sweep");
            end
        end

        // Directed register behaviour.
        clk_en = 1'b1;
        @(negedge clock);
`ifdef CLA_REG_OUT_EN
        drive(8'h80, 8'h80, 1'b0);
        @(negedge clock);
        check("reg_8080.q", {cout_q, sum_q}, 9'h100);
        #2 reset = 1'b1;
        #1 check("reg_async_rst.q", {cout_q, sum_q}, 9'h000);
        #1 reset = 1'b0;
        drive(8'h12, 8'h34, 1'b1);
        @(negedge clock);
        check("reg_1234.q", {cout_q, sum_q}, 9'h047);
`else
        drive(8'h80, 8'h80, 1'b0);
        #1 check("wire_8080.q", {cout_q, sum_q}, 9'h100);
        reset = 1'b1;
        #1 check("wire_rst.q", {cout_q, sum_q}, 9'h100);
        reset = 1'b0;
        drive(8'h12, 8'h34, 1'b1);
        #1 check("wire_1234.q", {cout_q, sum_q}, 9'h047);
        @(negedge clock);
`endif

        // Randomized clocked traffic with occasional asynchronous reset pulses.
        drive(8'($urandom), 8'($urandom), 1'($urandom));
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            exp_q = ref_add(a, b, cin);
            check_comb("rand");
            check("rand.q", {cout_q, sum_q}, exp_q);
            if ($urandom_range(0, 7) == 0) begin
                #1 reset = 1'b1;
                #1;
`ifdef CLA_REG_OUT_EN
                check("rand_rst.q", {cout_q, sum_q}, 9'h000);
`else
                check("rand_rst.q", {cout_q, sum_q}, exp_q);
`endif
                check_comb("rand_rst");
                #1 reset = 1'b0;
            end
            drive(8'($urandom), 8'($urandom), 1'($urandom));
`ifndef CLA_REG_OUT_EN
            #1 check("rand_wire.q", {cout_q, sum_q}, ref_add(a, b, cin));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cla_8_bit_block
